// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if: command-in and result-out valid/ready streams of the ALU sequencer
interface alu_cmd_sequencer_if #(parameter int NBITS = 32, parameter int TAGW = 4);
    logic             in_valid;
    logic             in_ready;
    logic [NBITS-1:0] in_a;
    logic [NBITS-1:0] in_b;
    logic [2:0]       in_op;
    logic [TAGW-1:0]  in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [NBITS-1:0] out_result;
    logic             out_carry;
    logic             out_ovf;
    logic             out_zero;
    logic [TAGW-1:0]  out_tag;
    modport master (
        output in_valid, in_a, in_b, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_carry, out_ovf, out_zero, out_tag
    );
    modport slave (
        input  in_valid, in_a, in_b, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_carry, out_ovf, out_zero, out_tag
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: FIFO-buffered command front-end that issues ALU ops and returns tagged results
module alu_cmd_sequencer #(
    parameter int NBITS = 32,
    parameter int DEPTH = 4,
    parameter int TAGW  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_cmd_sequencer_if.slave   cmd,
    output logic [NBITS-1:0]     alu_a,
    output logic [NBITS-1:0]     alu_b,
    output logic [2:0]           alu_op,
    input  logic [NBITS-1:0]     alu_result,
    input  logic                 alu_carryout,
    input  logic                 alu_overflow,
    output logic [15:0]          ops_done,
    output logic                 sticky_ovf,
    input  logic                 clr_sticky
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 2 * NBITS + 3 + TAGW;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [EW-1:0]    mem_q [DEPTH];
    logic [NBITS-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [2:0]       op_q, op_d;
    logic [TAGW-1:0]  tag_q, tag_d, otag_q, otag_d;
    logic             carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d, sticky_q, sticky_d;
    logic [15:0]      ops_done_q, ops_done_d;
    logic             push, pop, hs, empty, in_ready;
    logic [EW-1:0]    head;

    always_comb begin
        in_ready   = cnt_q != (AW + 1)'(DEPTH);
        empty      = cnt_q == '0;
        push       = cmd.in_valid && in_ready;
        hs         = state_q == HOLD && cmd.out_ready;
        pop        = !empty && (state_q == IDLE || hs);
        head       = mem_q[rd_q];
        wr_d       = push ? wr_q + AW'(1) : wr_q;
        rd_d       = pop ? rd_q + AW'(1) : rd_q;
        cnt_d      = cnt_q + (AW + 1)'(push) - (AW + 1)'(pop);
        state_d    = state_q == IDLE    ? (pop ? ISSUE : IDLE) :
                     state_q == ISSUE   ? CAPTURE :
                     state_q == CAPTURE ? HOLD :
                     hs                 ? (pop ? ISSUE : IDLE) : HOLD;
        {a_d, b_d, op_d, tag_d} = pop ? head : {a_q, b_q, op_q, tag_q};
        // ALU result is sampled only at the end of CAPTURE; held otherwise
        res_d      = state_q == CAPTURE ? alu_result : res_q;
        carry_d    = state_q == CAPTURE ? alu_carryout : carry_q;
        ovf_d      = state_q == CAPTURE ? alu_overflow : ovf_q;
        zero_d     = state_q == CAPTURE ? alu_result == '0 : zero_q;
        otag_d     = state_q == CAPTURE ? tag_q : otag_q;
        sticky_d   = (state_q == CAPTURE && alu_overflow) || (sticky_q && !clr_sticky);
        ops_done_d = ops_done_q + 16'(hs);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {cmd.in_a, cmd.in_b, cmd.in_op, cmd.in_tag};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            tag_q      <= '0;
            res_q      <= '0;
            carry_q    <= 1'b0;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b0;
            otag_q     <= '0;
            sticky_q   <= 1'b0;
            ops_done_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            tag_q      <= tag_d;
            res_q      <= res_d;
            carry_q    <= carry_d;
            ovf_q      <= ovf_d;
            zero_q     <= zero_d;
            otag_q     <= otag_d;
            sticky_q   <= sticky_d;
            ops_done_q <= ops_done_d;
        end
    end

    assign cmd.in_ready   = in_ready;
    assign cmd.out_valid  = state_q == HOLD;
    assign cmd.out_result = res_q;
    assign cmd.out_carry  = carry_q;
    assign cmd.out_ovf    = ovf_q;
    assign cmd.out_zero   = zero_q;
    assign cmd.out_tag    = otag_q;
    assign alu_a          = a_q;
    assign alu_b          = b_q;
    assign alu_op         = op_q;
    assign ops_done       = ops_done_q;
    assign sticky_ovf     = sticky_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed stimulus with a scoreboard queue and a decoupled result monitor
module tb_alu_cmd_sequencer;
    typedef struct {
        logic [31:0] res;
        logic        c, o, z;
        logic [3:0]  tag;
        int          gap;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [2:0]  alu_op;
    logic        alu_carryout, alu_overflow;
    logic [15:0] ops_done;
    logic        sticky_ovf;
    logic        clr_sticky = 1'b0;
    logic [31:0] ra = '0, rb = '0;
    logic [2:0]  rop = '0;
    logic [32:0] sum, dif;
    int          tests = 0, fails = 0, cyc = 0, last_hs = 0;
    exp_t        sb[$];
    exp_t        e;

    alu_cmd_sequencer_if #(.NBITS(32), .TAGW(4)) bus();

    alu_cmd_sequencer #(.NBITS(32), .DEPTH(4), .TAGW(4)) dut (
        .clk(clk), .reset(reset), .cmd(bus),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_carryout(alu_carryout), .alu_overflow(alu_overflow),
        .ops_done(ops_done), .sticky_ovf(sticky_ovf), .clr_sticky(clr_sticky)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // ALU stand-in with registered inputs: 0/1 add, 2 subtract, others AND
    always @(posedge clk) begin
        ra  <= alu_a;
        rb  <= alu_b;
        rop <= alu_op;
    end
    always_comb begin
        sum          = {1'b0, ra} + {1'b0, rb};
        dif          = {1'b0, ra} - {1'b0, rb};
        alu_result   = rop <= 3'd1 ? sum[31:0] : rop == 3'd2 ? dif[31:0] : ra & rb;
        alu_carryout = rop <= 3'd1 ? sum[32] : rop == 3'd2 ? ra >= rb : 1'b0;
        alu_overflow = rop <= 3'd1 ? (ra[31] == rb[31]) && (sum[31] != ra[31]) :
                       rop == 3'd2 ? (ra[31] != rb[31]) && (dif[31] != ra[31]) : 1'b0;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got tag %0h expected none", bus.out_tag);
            end else begin
                e = sb.pop_front();
                chk("out_result", bus.out_result, e.res);
                chk("out_tag", bus.out_tag, e.tag);
                chk("out_carry", bus.out_carry, e.c);
                chk("out_ovf", bus.out_ovf, e.o);
                chk("out_zero", bus.out_zero, e.z);
                if (e.gap != 0) chk("result_spacing", cyc - last_hs, e.gap);
            end
            last_hs = cyc;
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        input logic [3:0] tag, input logic [31:0] res, input logic c,
                        input logic o, input logic z, input int gap);
        int n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a = a;
        bus.in_b = b;
        bus.in_op = op;
        bus.in_tag = tag;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) chk("accept_timeout", 0, 1);
        else sb.push_back('{res, c, o, z, tag, gap});
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) chk("result_timeout", sb.size(), 0);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.in_op = '0;
        bus.in_tag = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_ops_done", ops_done, 0);
        chk("rst_sticky", sticky_ovf, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_out_result", bus.out_result, 0);
        reset = 1'b1;

        // single op with latency check
        send(32'd5, 32'd7, 3'b000, 4'd3, 32'd12, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("issue_alu_a", alu_a, 5);
        chk("issue_alu_b", alu_b, 7);
        @(negedge clk);
        chk("latency_not_yet", bus.out_valid, 0);
        @(negedge clk);
        chk("latency_valid", bus.out_valid, 1);
        wait_empty();
        chk("ops_done_1", ops_done, 1);

        send(32'h7FFF_FFFF, 32'd1, 3'b001, 4'd1, 32'h8000_0000, 0, 1, 0, 0);
        wait_empty();
        chk("sticky_set", sticky_ovf, 1);
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        chk("sticky_cleared", sticky_ovf, 0);

        send(32'd9, 32'd9, 3'b010, 4'd2, 32'd0, 1, 0, 1, 0);
        send(32'd10, 32'd3, 3'b010, 4'd4, 32'd7, 1, 0, 0, 0);
        send(32'hFFFF_FFFF, 32'd1, 3'b000, 4'd6, 32'd0, 1, 0, 1, 0);
        wait_empty();
        chk("ops_done_5", ops_done, 5);
        chk("sticky_stays_clear", sticky_ovf, 0);

        // reset during CAPTURE of the first of three commands
        send(32'h55, 32'd1, 3'b000, 4'd8, 32'h56, 0, 0, 0, 0);
        send(32'h66, 32'd1, 3'b000, 4'd9, 32'h67, 0, 0, 0, 0);
        send(32'h77, 32'd1, 3'b000, 4'd10, 32'h78, 0, 0, 0, 0);
        #1 reset = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_in_ready", bus.in_ready, 1);
        chk("mid_rst_alu_a", alu_a, 0);
        chk("mid_rst_out_tag", bus.out_tag, 0);
        chk("mid_rst_ops_done", ops_done, 0);
        chk("mid_rst_out_zero", bus.out_zero, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        chk("post_rst_idle", bus.out_valid, 0);

        // backpressure: five accepted, sixth refused
        bus.out_ready = 1'b0;
        send(32'd1, 32'h10, 3'b000, 4'd0, 32'h11, 0, 0, 0, 0);
        for (int i = 1; i < 5; i++)
            send(32'(i + 1), 32'h10, 3'b000, 4'(i), 32'(i + 17), 0, 0, 0, 3);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a = 32'd6;
        bus.in_tag = 4'd5;
        for (int i = 0; i < 4; i++) begin
            chk("full_in_ready", bus.in_ready, 0);
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_tag", bus.out_tag, 0);
            chk("hold_result", bus.out_result, 32'h11);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        wait_empty();
        repeat (6) @(negedge clk);
        chk("drain_ops_done", ops_done, 5);
        chk("drain_in_ready", bus.in_ready, 1);

        // counter wrap
        force dut.ops_done_q = 16'hFFFE;
        #1;
        release dut.ops_done_q;
        send(32'd1, 32'd2, 3'b000, 4'd7, 32'd3, 0, 0, 0, 0);
        wait_empty();
        chk("ops_done_ffff", ops_done, 16'hFFFF);
        send(32'd1, 32'd2, 3'b000, 4'd8, 32'd3, 0, 0, 0, 0);
        wait_empty();
        chk("ops_done_wrap", ops_done, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command front-end for the `my_alu` datapath.
- Accepts ALU commands (A, B, opcode, tag) over a valid/ready handshake and buffers them in a small FIFO.
- Issues one command at a time to the ALU's registered inputs and captures the ALU's registered result and flags one cycle later.
- Presents each tagged result downstream on a second valid/ready handshake, and maintains a completed-op counter and a sticky overflow flag.

## Interface
Parameters:
- `NBITS`, 32, operand/result width; must match the ALU.
- `DEPTH`, 4, command FIFO depth; power of two, ≥2.
- `TAGW`, 4, command tag width.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: asynchronous, active-low reset.
- `in_valid` in 1: command valid.
- `in_ready` out 1: FIFO can accept a command.
- `in_a` in NBITS: operand A.
- `in_b` in NBITS: operand B.
- `in_op` in 3: ALU opcode, passed through uninterpreted.
- `in_tag` in TAGW: command tag.
- `alu_a` out NBITS: drives ALU `A`.
- `alu_b` out NBITS: drives ALU `B`.
- `alu_op` out 3: drives ALU `opcode`.
- `alu_result` in NBITS: from ALU.
- `alu_carryout` in 1: from ALU.
- `alu_overflow` in 1: from ALU.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_result` out NBITS: captured result.
- `out_carry` out 1: captured carry flag.
- `out_ovf` out 1: captured overflow flag.
- `out_zero` out 1: captured zero flag.
- `out_tag` out TAGW: tag of the captured command.
- `ops_done` out 16: count of results accepted downstream; wraps at 0xFFFF→0.
- `sticky_ovf` out 1: set by any captured overflow.
- `clr_sticky` in 1: synchronous clear of `sticky_ovf`.

## Operation
FIFO:
- A push occurs when `in_valid && in_ready`.
- `in_ready = (count != DEPTH)`, from registered count only; there is no full-bypass.
- Read/write pointers wrap modulo DEPTH.

FSM states are IDLE, ISSUE, CAPTURE and HOLD.
- **IDLE:** if the FIFO is non-empty, pop the head into the issue registers (`alu_a/alu_b/alu_op` and the tag), then go to ISSUE.
- **ISSUE (1 cycle):** issue registers stay stable on `alu_*`; the ALU samples them at the end of this cycle. Go to CAPTURE.
- **CAPTURE (1 cycle):** at the end of the cycle, register `alu_result`, `alu_carryout` and `alu_overflow` into `out_*`.
  - `out_zero = (alu_result == 0)` is computed locally; the ALU zero output is not used.
  - Set `sticky_ovf` if `alu_overflow` is high.
  - Go to HOLD.
- **HOLD:** `out_valid = 1`. Hold all `out_*` stable until `out_ready`.
  - On the handshake, increment `ops_done`.
  - If the FIFO is non-empty, pop the next command and go to ISSUE; otherwise go to IDLE.

General rules:
- `alu_a/alu_b/alu_op` retain their last issued values outside ISSUE; they change only on a pop.
- `out_valid` is high only in HOLD.
- Push and pop in the same cycle are legal; count is unchanged.
- If `clr_sticky` and a capture with overflow occur in the same cycle, the set wins.
- Reset (async, active-low):
  - FIFO empty, state IDLE.
  - `in_ready = 1`; `out_valid = 0`.
  - `alu_a/alu_b/alu_op`, all `out_*`, `ops_done` and `sticky_ovf` are 0.
  - Reset mid-operation discards the in-flight command and all buffered commands.

## Timing
- Command accepted at edge E0 into an empty, IDLE block:
  - popped at E1;
  - ISSUE during cycle E1–E2, ALU captures at E2;
  - CAPTURE during cycle E2–E3;
  - `out_valid` high from E3.
- Latency from accept to `out_valid` is 3 cycles.
- Back-to-back throughput with `out_ready = 1` is one result per 3 cycles (HOLD→ISSUE→CAPTURE→HOLD).
- With `out_ready` held low, the block absorbs one in-flight command plus DEPTH buffered commands before `in_ready` drops.
- `in_ready` rises the cycle after a pop frees a slot.

## Test plan
- **Single op:** `in_a=5`, `in_b=7`, `in_op=000`, `in_tag=3`, `out_ready=1`.
  - `out_valid` 3 cycles after accept, with `out_result=12`, `out_tag=3`, `out_zero=0`.
  - `ops_done=1`.
- **Signed overflow:** `in_op=001`, `A=0x7FFFFFFF`, `B=1`.
  - `out_result=0x80000000`, `out_ovf=1`, `sticky_ovf=1`.
  - Pulse `clr_sticky`, then `sticky_ovf=0`.
- **Zero flag:** `in_op=010`, `A=9`, `B=9`.
  - `out_result=0`, `out_zero=1`; the previous op's zero state does not leak through.
- **Backpressure and full:**
  - With `out_ready=0`, drive 6 commands with tags 0..5: exactly 5 are accepted, then `in_ready=0` and `out_tag=0` holds stable.
  - Release `out_ready`: tags 0..4 emerge in order, one per 3 cycles, and `ops_done=5`.
- **Reset mid-operation:** with 3 commands queued, assert `reset` low during CAPTURE.
  - All outputs go to 0 immediately and `in_ready=1`.
  - After release, no stale results appear.
- **Counter wrap:** preload via 65536 completed ops (or force). `ops_done` goes from 0xFFFF to 0.
